gpio_irq_ctrl: RTL and testbench

Multi-channel interrupt controller for asynchronous GPIO inputs. Each channel gets a two-stage synchronizer and an edge detector. A per-channel mode selects which condition sets a pending bit. A fixed-priority arbiter and a request/acknowledge FSM present one pending channel at a time to the core interrupt logic. It sits between the GPIO pad inputs and the core's external-interrupt line; software configuration reaches it through the GPIO register block.

---
 rtl/gpio_irq_ctrl.sv | 103 ++++++++++
 tb/tb_gpio_irq_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: per-channel synchronizer, edge/level trigger, pending
// bits, and a fixed-priority request/acknowledge handshake toward the core.
module gpio_irq_ctrl #(
  parameter  int NUM = 8,
  localparam int IDW = $clog2(NUM)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NUM-1:0]   sig_i,
  input  logic [NUM-1:0]   en_i,
  input  logic [2*NUM-1:0] mode_i,
  input  logic [NUM-1:0]   clr_i,
  output logic [NUM-1:0]   pend_o,
  output logic             irq_o,
  output logic [IDW-1:0]   irq_id_o,
  input  logic             ack_i
);
  // state | meaning
  // IDLE  | no request outstanding; latch lowest eligible channel if any
  // REQ   | irq_o high for id_q until ack or withdrawal

  typedef enum logic {IDLE, REQ} state_e;

  state_e         state_q, state_d;
  logic [NUM-1:0] sync1_q, s_q, prev_q;
  logic [NUM-1:0] pend_q, pend_d;
  logic [NUM-1:0] re, fe, trig, elig, ack_clr;
  logic [IDW-1:0] id_q, id_d, lowest;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      s_q     <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      sync1_q <= sig_i;
      s_q     <= sync1_q;
      prev_q  <= s_q;
      pend_q  <= pend_d;
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  assign re = s_q & ~prev_q;
  assign fe = ~s_q & prev_q;

  always_comb begin
    trig = '0;
    for (int k = 0; k < NUM; k++) begin
      case (mode_i[2*k +: 2])
        2'b00:   trig[k] = re[k];
        2'b01:   trig[k] = fe[k];
        2'b10:   trig[k] = re[k] | fe[k];
        default: trig[k] = s_q[k];
      endcase
    end
  end

  assign elig = pend_q & en_i;

  // Scan downward so the lowest eligible index is the one left standing.
  always_comb begin
    lowest = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      if (elig[k]) lowest = IDW'(k);
    end
  end

  always_comb begin
    ack_clr = '0;
    if (state_q == REQ && ack_i) ack_clr[id_q] = 1'b1;
  end

  // A new trigger wins over any clear in the same cycle.
  assign pend_d = (en_i & trig) | (pend_q & ~(clr_i | ack_clr));

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = REQ;
          id_d    = lowest;
        end
      end
      REQ: begin
        if (ack_i)              state_d = IDLE;
        else if (!elig[id_q])   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pend_o   = pend_q;
  assign irq_o    = (state_q == REQ);
  assign irq_id_o = id_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: a per-cycle vector table for the basic
// edge/priority/enable behaviour plus hand-written multi-cycle sequences.
module tb_gpio_irq_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  sig_i = '0;
  logic [7:0]  en_i = '0;
  logic [15:0] mode_i = '0;
  logic [7:0]  clr_i = '0;
  logic        ack_i = 1'b0;
  logic [7:0]  pend_o;
  logic        irq_o;
  logic [2:0]  irq_id_o;

  int tests = 0;
  int fails = 0;

  gpio_irq_ctrl #(.NUM(8)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .sig_i    (sig_i),
    .en_i     (en_i),
    .mode_i   (mode_i),
    .clr_i    (clr_i),
    .pend_o   (pend_o),
    .irq_o    (irq_o),
    .irq_id_o (irq_id_o),
    .ack_i    (ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] sig;
    logic [7:0] en;
    logic [7:0] clr;
    logic       ack;
    logic [7:0] pend;
    logic       irq;
    logic [2:0] id;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] sig, input logic [7:0] en, input logic ack,
                     input logic [7:0] pend, input logic irq, input logic [2:0] id);
    vec_t v;
    v.sig = sig; v.en = en; v.clr = 8'h00; v.ack = ack;
    v.pend = pend; v.irq = irq; v.id = id;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    sig_i = '0; en_i = '0; clr_i = '0; ack_i = 1'b0; mode_i = '0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  // Drives a pulse of the given width on one channel and acks every request seen.
  task automatic pulse_run(input int ch, input int width,
                           output int nreq, output int first, output int badid);
    nreq = 0; first = -1; badid = 0;
    for (int i = 0; i < 16; i++) begin
      sig_i[ch] = (i < width);
      step();
      if (irq_o) begin
        nreq++;
        if (first < 0) first = i;
        if (int'(irq_id_o) != ch) badid++;
        ack_i = 1'b1;
      end else begin
        ack_i = 1'b0;
      end
    end
    ack_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nreq, first, badid;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_pend", pend_o, 8'h00);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_id", irq_id_o, 3'd0);
    step();
    step();
    rst_ni = 1'b1;

    // Table: rising mode on all channels; ch3 alone, then ch2+ch5 together, then en=0.
    add(8'h08, 8'hFF, 0, 8'h00, 0, 3'd0);
    add(8'h08, 8'hFF, 0, 8'h00, 0, 3'd0);
    add(8'h08, 8'hFF, 0, 8'h08, 0, 3'd0);
    add(8'h08, 8'hFF, 0, 8'h08, 1, 3'd3);
    add(8'h08, 8'hFF, 1, 8'h00, 0, 3'd3);
    add(8'h08, 8'hFF, 0, 8'h00, 0, 3'd3);
    add(8'h2C, 8'hFF, 0, 8'h00, 0, 3'd3);
    add(8'h2C, 8'hFF, 0, 8'h00, 0, 3'd3);
    add(8'h2C, 8'hFF, 0, 8'h24, 0, 3'd3);
    add(8'h2C, 8'hFF, 0, 8'h24, 1, 3'd2);
    add(8'h2C, 8'hFF, 1, 8'h20, 0, 3'd2);
    add(8'h2C, 8'hFF, 0, 8'h20, 1, 3'd5);
    add(8'h2C, 8'hFF, 1, 8'h00, 0, 3'd5);
    add(8'h2C, 8'hFF, 0, 8'h00, 0, 3'd5);
    add(8'h00, 8'h00, 0, 8'h00, 0, 3'd5);
    add(8'h00, 8'h00, 0, 8'h00, 0, 3'd5);
    add(8'hFF, 8'h00, 0, 8'h00, 0, 3'd5);
    add(8'hFF, 8'h00, 0, 8'h00, 0, 3'd5);
    add(8'hFF, 8'h00, 0, 8'h00, 0, 3'd5);
    add(8'hFF, 8'h00, 0, 8'h00, 0, 3'd5);
    add(8'hFF, 8'hFF, 0, 8'h00, 0, 3'd5);
    add(8'hFF, 8'hFF, 0, 8'h00, 0, 3'd5);

    mode_i = 16'h0000;
    foreach (vecs[i]) begin
      sig_i = vecs[i].sig;
      en_i  = vecs[i].en;
      clr_i = vecs[i].clr;
      ack_i = vecs[i].ack;
      step();
      chk($sformatf("vec%0d_pend", i), pend_o, vecs[i].pend);
      chk($sformatf("vec%0d_irq", i), irq_o, vecs[i].irq);
      chk($sformatf("vec%0d_id", i), irq_id_o, vecs[i].id);
    end
    ack_i = 1'b0;

    // Level mode on ch1: ack does not clear while the input stays high.
    do_reset();
    en_i = 8'hFF; mode_i = 16'h000C; sig_i = 8'h02;
    step(); step(); step();
    chk("lvl_e2_irq", irq_o, 1'b0);
    step();
    chk("lvl_e3_irq", irq_o, 1'b1);
    chk("lvl_e3_id", irq_id_o, 3'd1);
    chk("lvl_e3_pend", pend_o, 8'h02);
    ack_i = 1'b1; step(); ack_i = 1'b0;
    chk("lvl_ack_irq", irq_o, 1'b0);
    chk("lvl_ack_pend", pend_o, 8'h02);
    step();
    chk("lvl_rearm_irq", irq_o, 1'b1);
    chk("lvl_rearm_id", irq_id_o, 3'd1);
    sig_i = 8'h00;
    step(); step();
    chk("lvl_hold_irq", irq_o, 1'b1);
    ack_i = 1'b1; step(); ack_i = 1'b0;
    chk("lvl_final_pend", pend_o, 8'h00);
    chk("lvl_final_irq", irq_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("lvl_quiet%0d_irq", i), irq_o, 1'b0);
    end

    // Both-edge mode: one request per edge of a 4-cycle pulse.
    do_reset();
    en_i = 8'hFF; mode_i = 16'h0002;
    pulse_run(0, 4, nreq, first, badid);
    chk("both_nreq", nreq, 2);
    chk("both_first", first, 3);
    chk("both_badid", badid, 0);

    // Falling mode: a single request after the falling edge.
    do_reset();
    en_i = 8'hFF; mode_i = 16'h0001;
    pulse_run(0, 4, nreq, first, badid);
    chk("fall_nreq", nreq, 1);
    chk("fall_first", first, 7);
    chk("fall_badid", badid, 0);

    // Software clear during REQ withdraws the request one cycle later.
    do_reset();
    en_i = 8'hFF; mode_i = 16'h0000; sig_i = 8'h10;
    step(); step(); step(); step();
    chk("clr_req_irq", irq_o, 1'b1);
    chk("clr_req_id", irq_id_o, 3'd4);
    chk("clr_req_pend", pend_o, 8'h10);
    clr_i = 8'h10; step(); clr_i = 8'h00;
    chk("clr_pend", pend_o, 8'h00);
    chk("clr_irq_still", irq_o, 1'b1);
    step();
    chk("clr_withdraw_irq", irq_o, 1'b0);
    step(); step();
    chk("clr_quiet_irq", irq_o, 1'b0);

    // Asynchronous reset mid-request, input high across release.
    do_reset();
    en_i = 8'hFF; mode_i = 16'h0000; sig_i = 8'h40;
    step(); step(); step(); step();
    chk("rr_req_irq", irq_o, 1'b1);
    chk("rr_req_id", irq_id_o, 3'd6);
    #2 rst_ni = 1'b0;
    #1;
    chk("rr_async_irq", irq_o, 1'b0);
    chk("rr_async_pend", pend_o, 8'h00);
    chk("rr_async_id", irq_id_o, 3'd0);
    step(); step();
    rst_ni = 1'b1;
    step(); step(); step();
    chk("rr_e2_irq", irq_o, 1'b0);
    chk("rr_e2_pend", pend_o, 8'h40);
    step();
    chk("rr_e3_irq", irq_o, 1'b1);
    chk("rr_e3_id", irq_id_o, 3'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
